instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch.sv | 117 +++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect from execute,
// and the instruction stream handed to decode.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, out_ready
    );

    // Memory / execute / decode side.
    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential PC generation, in-order memory requests with
// live/stale tracking across redirects, and a small {instr, pc} FIFO to decode.
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic         clk,
    input logic         rst_n,
    instr_fetch_if.master bus
);
    localparam int          AW    = $clog2(DEPTH);
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam int          OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] MAX_U = MAX_OUTSTANDING;
    localparam logic [31:0] DEP_U = DEPTH;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [31:0]     fetch_pc, pc_nxt;
    logic [OW-1:0]   live_cnt, stale_cnt, live_nxt, stale_nxt;
    logic [31:0]     os_total;
    logic [31:0]     rsp_pc;
    logic            req_hs, deq, rsp_live, rsp_stale, enq;
    entry_t          head;
    logic            unused_bits;

    // Low redirect bits are forced to zero, so they are intentionally dropped.
    assign unused_bits = ^bus.redirect_pc[1:0];

    // Credit uses registered counts only: no same-cycle dequeue or response credit.
    assign bus.imem_req_valid = (32'(live_cnt) + 32'(stale_cnt) < MAX_U) &&
                                (32'(live_cnt) + 32'(count) < DEP_U);
    assign bus.imem_req_addr  = fetch_pc;

    assign req_hs    = bus.imem_req_valid && bus.imem_req_ready;
    assign deq       = bus.out_valid && bus.out_ready;
    // Responses come back in order and stale requests are always the oldest,
    // so a response is stale exactly while the stale count is non-zero.
    assign rsp_stale = bus.imem_rsp_valid && (stale_cnt != '0);
    assign rsp_live  = bus.imem_rsp_valid && (stale_cnt == '0);
    assign enq       = rsp_live && !bus.redirect_valid;
    // Live requests are consecutive words ending just below fetch_pc.
    assign rsp_pc    = fetch_pc - (32'(live_cnt) << 2);

    assign head          = fifo_mem[rd_ptr];
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = bus.out_valid ? head.instr : 32'h0;
    assign bus.out_pc    = bus.out_valid ? head.pc    : 32'h0;

    // Next-state for PC, outstanding counters and FIFO pointers.
    always_comb begin
        pc_nxt    = fetch_pc;
        live_nxt  = live_cnt;
        stale_nxt = stale_cnt;
        count_nxt = count;
        wr_nxt    = wr_ptr;
        rd_nxt    = rd_ptr;
        os_total  = 32'(live_cnt) + 32'(stale_cnt) + 32'(req_hs) - 32'(bus.imem_rsp_valid);
        if (bus.redirect_valid) begin
            pc_nxt    = {bus.redirect_pc[31:2], 2'b00};
            live_nxt  = '0;
            stale_nxt = (os_total > MAX_U) ? OW'(MAX_OUTSTANDING) : OW'(os_total);
            count_nxt = '0;
            wr_nxt    = '0;
            rd_nxt    = '0;
        end else begin
            if (req_hs)
                pc_nxt = fetch_pc + 32'd4;
            if (req_hs && !rsp_live)
                live_nxt = live_cnt + OW'(1);
            else if (!req_hs && rsp_live)
                live_nxt = live_cnt - OW'(1);
            if (rsp_stale)
                stale_nxt = stale_cnt - OW'(1);
            if (enq)
                wr_nxt = wr_ptr + AW'(1);
            if (deq)
                rd_nxt = rd_ptr + AW'(1);
            if (enq && !deq)
                count_nxt = count + CW'(1);
            else if (!enq && deq)
                count_nxt = count - CW'(1);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_VECTOR;
            live_cnt  <= '0;
            stale_cnt <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            fetch_pc  <= pc_nxt;
            live_cnt  <= live_nxt;
            stale_cnt <= stale_nxt;
            count     <= count_nxt;
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
        end
    end

    // FIFO storage; contents are don't-care while empty, outputs are gated.
    always_ff @(posedge clk) begin
        if (rst_n && enq)
            fifo_mem[wr_ptr] <= '{instr: bus.imem_rsp_data, pc: rsp_pc};
    end
endmodule
